// File: rtl/coincidence_readout.sv
// coincidence_readout: snapshots detector counters at window end and streams them as an indexed word frame
module coincidence_readout #(
   parameter  int NCHAN  = 4,
   parameter  int NBITS  = 4,
   localparam int NPAIRS = NCHAN*(NCHAN-1)/2,
   localparam int NWORDS = 1+NCHAN+NPAIRS
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Enable_i,
   input  logic [NBITS-1:0]        nCycles_i,
   input  logic [NBITS-1:0]        Cnt_Clk_i,
   input  logic [NCHAN*NBITS-1:0]  Cnt_chann_i,
   input  logic [NPAIRS*NBITS-1:0] Cnt_pairs_i,
   output logic [NBITS-1:0]        Data_o,
   output logic [7:0]              Idx_o,
   output logic                    Valid_o,
   input  logic                    Ready_i,
   output logic                    Last_o,
   output logic                    Restart_o,
   output logic                    Busy_o,
   output logic [15:0]             Frames_o
);
   localparam int IW = $clog2(NWORDS);
   typedef enum logic [2:0] {IDLE, ARMED, SEND, RESTART, DRAIN} state_t;
   state_t state, state_n;
   logic [NBITS-1:0] shadow [NWORDS];
   logic [7:0] idx_n;
   logic capture, done;
   assign Data_o = shadow[Idx_o[IW-1:0]];
   // next state, word index and capture/frame-complete strobes
   always_comb begin
      state_n = state;
      idx_n   = Idx_o;
      capture = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE:    state_n = Enable_i ? ARMED : IDLE;
         ARMED:   if (!Enable_i) state_n = IDLE;
                  else if (Cnt_Clk_i >= nCycles_i) begin
                     capture = 1'b1;
                     state_n = SEND;
                     idx_n   = 8'd0;
                  end
         SEND:    if (Ready_i) begin
                     done    = Last_o;
                     state_n = Last_o ? RESTART : SEND;
                     idx_n   = Last_o ? 8'd0 : Idx_o + 8'd1;
                  end
         RESTART: state_n = DRAIN;
         DRAIN:   state_n = (Cnt_Clk_i == '0) ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
   end
   // state and registered handshake/status outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         Idx_o     <= 8'd0;
         Valid_o   <= 1'b0;
         Last_o    <= 1'b0;
         Restart_o <= 1'b0;
         Busy_o    <= 1'b0;
         Frames_o  <= 16'd0;
      end else begin
         state     <= state_n;
         Idx_o     <= idx_n;
         Valid_o   <= state_n == SEND;
         Last_o    <= (state_n == SEND) && (idx_n == 8'(NWORDS-1));
         Restart_o <= state_n == RESTART;
         Busy_o    <= state_n != IDLE;
         Frames_o  <= Frames_o + 16'(done);
      end
   end
   // shadow copy of clock, channel and pair counters taken at window end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NWORDS; i++) shadow[i] <= '0;
      end else if (capture) begin
         shadow[0] <= Cnt_Clk_i;
         for (int i = 0; i < NCHAN; i++) shadow[1+i] <= Cnt_chann_i[i*NBITS +: NBITS];
         for (int k = 0; k < NPAIRS; k++) shadow[1+NCHAN+k] <= Cnt_pairs_i[k*NBITS +: NBITS];
      end
   end
endmodule

// File: tb/tb_coincidence_readout.sv
// tb_coincidence_readout: randomized scoreboard bench for the coincidence readout frame streamer
module tb_coincidence_readout;
   localparam int NCHAN = 4, NBITS = 4, NPAIRS = 6, NWORDS = 11;
   localparam int CW = NCHAN*NBITS, PW = NPAIRS*NBITS;
   logic Clk = 0, Rst = 1, Enable_i = 0, Ready_i = 0;
   logic [NBITS-1:0] nCycles_i = '0, Cnt_Clk_i = '0;
   logic [CW-1:0] Cnt_chann_i = '0;
   logic [PW-1:0] Cnt_pairs_i = '0;
   logic [NBITS-1:0] Data_o;
   logic [7:0] Idx_o;
   logic Valid_o, Last_o, Restart_o, Busy_o;
   logic [15:0] Frames_o;
   coincidence_readout #(.NCHAN(NCHAN), .NBITS(NBITS)) dut (
      .Clk(Clk), .Rst(Rst), .Enable_i(Enable_i), .nCycles_i(nCycles_i), .Cnt_Clk_i(Cnt_Clk_i),
      .Cnt_chann_i(Cnt_chann_i), .Cnt_pairs_i(Cnt_pairs_i), .Data_o(Data_o), .Idx_o(Idx_o),
      .Valid_o(Valid_o), .Ready_i(Ready_i), .Last_o(Last_o), .Restart_o(Restart_o),
      .Busy_o(Busy_o), .Frames_o(Frames_o));
   always #5 Clk = ~Clk;
   typedef struct packed {logic [NBITS-1:0] d; logic [7:0] i; logic l;} word_t;
   word_t exp_q[$];
   int n_checks = 0, n_fail = 0, restarts = 0, exp_restarts = 0, ready_mode = 0, ph = 0;
   logic [15:0] exp_frames = 16'd0;
   bit auto_cnt = 1, scramble = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // monitor: pops the scoreboard on every accepted word and checks handshake rules
   bit hold = 0, prev_r = 0;
   word_t held, e;
   always @(negedge Clk) begin
      if (Rst) begin
         hold = 0;
         prev_r = 0;
      end else begin
         chk("last_without_valid", 32'(Last_o & ~Valid_o), 0);
         if (Restart_o) begin
            restarts++;
            chk("restart_width", 32'(prev_r), 0);
            chk("restart_with_valid", 32'(Valid_o), 0);
         end
         prev_r = Restart_o;
         if (hold) begin
            chk("hold_valid", 32'(Valid_o), 1);
            chk("hold_word", 32'({Data_o, Idx_o, Last_o}), 32'(held));
         end
         if (Valid_o && Ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got idx %0d data %0d expected none", Idx_o, Data_o);
            end else begin
               e = exp_q.pop_front();
               chk("word_idx", 32'(Idx_o), 32'(e.i));
               chk("word_data", 32'(Data_o), 32'(e.d));
               chk("word_last", 32'(Last_o), 32'(e.l));
            end
         end
         hold = Valid_o && !Ready_i;
         held = {Data_o, Idx_o, Last_o};
      end
   end
   // one clock of stimulus: detector clock counter model, sink readiness, mid-frame counter churn
   task automatic step();
      @(posedge Clk);
      #1;
      if (auto_cnt) Cnt_Clk_i = (Restart_o || !Enable_i) ? '0 : Cnt_Clk_i + 1'b1;
      case (ready_mode)
         0: Ready_i = 1'b1;
         1: begin Ready_i = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
         default: Ready_i = 1'($urandom_range(0, 1));
      endcase
      if (scramble && Valid_o) begin
         Cnt_chann_i = CW'($urandom);
         Cnt_pairs_i = PW'($urandom);
      end
   endtask
   task automatic push_frame(input logic [NBITS-1:0] c0, input logic [CW-1:0] ch, input logic [PW-1:0] pr);
      logic [NBITS-1:0] w [NWORDS];
      w[0] = c0;
      for (int i = 0; i < NCHAN; i++) w[1+i] = ch[i*NBITS +: NBITS];
      for (int k = 0; k < NPAIRS; k++) w[1+NCHAN+k] = pr[k*NBITS +: NBITS];
      for (int i = 0; i < NWORDS; i++) exp_q.push_back({w[i], 8'(i), 1'(i == NWORDS-1)});
   endtask
   task automatic run_frame(input string name, input logic [NBITS-1:0] ncyc, input logic [CW-1:0] ch,
                            input logic [PW-1:0] pr, input int mode, input bit keep, input bit rearm);
      int k = 0, n = 0;
      logic [NBITS-1:0] c = '0;
      bit seen = 0;
      nCycles_i = ncyc;
      Cnt_chann_i = ch;
      Cnt_pairs_i = pr;
      ready_mode = mode;
      ph = 0;
      push_frame(ncyc, ch, pr);
      exp_frames++;
      exp_restarts++;
      Enable_i = 1'b1;
      while (!seen && k < 400) begin
         c = Cnt_Clk_i;
         step();
         k++;
         seen = Valid_o;
      end
      chk({name, "_valid_seen"}, 32'(seen), 1);
      chk({name, "_capture_cnt"}, 32'(c), 32'(ncyc));
      if (!rearm) chk({name, "_capture_latency"}, k, (ncyc == 0) ? 2 : int'(ncyc) + 1);
      while (Valid_o && n < 400) begin
         step();
         n++;
      end
      if (mode == 0) chk({name, "_burst_len"}, n, NWORDS);
      chk({name, "_restart"}, 32'(Restart_o), 1);
      chk({name, "_frames"}, 32'(Frames_o), 32'(exp_frames));
      chk({name, "_all_words"}, exp_q.size(), 0);
      if (!keep) Enable_i = 1'b0;
      step();
      chk({name, "_restart_once"}, 32'(Restart_o), 0);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int k;
      repeat (3) step();
      Rst = 1'b0;
      step();
      chk("reset_outs", 32'({Valid_o, Last_o, Restart_o, Busy_o}), 0);
      chk("reset_idx", 32'(Idx_o), 0);
      chk("reset_data", 32'(Data_o), 0);
      chk("reset_frames", 32'(Frames_o), 0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle_quiet", 32'({Valid_o, Busy_o, Restart_o}), 0);
      end
      run_frame("nominal", 4'd10, {4'd7, 4'd0, 4'd5, 4'd3}, {4'd4, 4'd0, 4'd0, 4'd2, 4'd0, 4'd1}, 0, 0, 0);
      repeat (20) step();
      chk("nominal_idle", 32'(Busy_o), 0);
      scramble = 1;
      run_frame("backpressure", 4'd10, CW'($urandom), PW'($urandom), 1, 0, 0);
      repeat (20) step();
      for (int r = 0; r < 4; r++) begin
         run_frame("random", 4'($urandom_range(1, 15)), CW'($urandom), PW'($urandom), 2, 0, 0);
         repeat (20) step();
      end
      scramble = 0;
      nCycles_i = 4'd10;
      Enable_i = 1'b1;
      repeat (5) step();
      chk("abort_cnt_below", 32'(Cnt_Clk_i < nCycles_i), 1);
      Enable_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("abort_quiet", 32'({Valid_o, Restart_o}), 0);
      end
      chk("abort_idle", 32'(Busy_o), 0);
      auto_cnt = 0;
      Cnt_Clk_i = '0;
      run_frame("zero_window", 4'd0, '0, '0, 0, 0, 0);
      repeat (5) step();
      auto_cnt = 1;
      nCycles_i = 4'd10;
      Cnt_chann_i = CW'($urandom);
      Cnt_pairs_i = PW'($urandom);
      push_frame(4'd10, Cnt_chann_i, Cnt_pairs_i);
      Enable_i = 1'b1;
      k = 0;
      while (!(Valid_o && Idx_o == 8'd4) && k < 400) begin
         step();
         k++;
      end
      chk("rst_abort_reached_idx4", 32'(Idx_o), 4);
      Rst = 1'b1;
      Enable_i = 1'b0;
      exp_q.delete();
      exp_frames = 16'd0;
      step();
      Rst = 1'b0;
      chk("rst_abort_valid", 32'(Valid_o), 0);
      chk("rst_abort_frames", 32'(Frames_o), 0);
      chk("rst_abort_idx", 32'(Idx_o), 0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("rst_abort_quiet", 32'({Valid_o, Restart_o}), 0);
      end
      force dut.Frames_o = 16'hFFFF;
      step();
      step();
      release dut.Frames_o;
      exp_frames = 16'hFFFF;
      step();
      chk("preload_frames", 32'(Frames_o), 32'hFFFF);
      run_frame("wrap", 4'd10, CW'($urandom), PW'($urandom), 0, 1, 0);
      run_frame("rearm", 4'd10, CW'($urandom), PW'($urandom), 2, 0, 1);
      repeat (20) step();
      chk("restart_total", restarts, exp_restarts);
      chk("end_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
